// File: rtl/semiauto_motion_exec_pkg.sv
// Shared encodings for the semi-auto motion executor: command codes and FSM states
// (same values as the decision FSM), plus the registered output bundle and its decode.
package semiauto_motion_exec_pkg;

    typedef enum logic [3:0] {
        CMD_STOP  = 4'b0000,
        CMD_FWD   = 4'b0001,
        CMD_LEFT  = 4'b0100,
        CMD_RIGHT = 4'b1000
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FWD  = 2'b01,
        ST_TURN = 2'b10,
        ST_COOL = 2'b11
    } state_e;

    typedef struct packed {
        logic cmd_ready;
        logic busy;
        logic done;
        logic motor_fwd;
        logic motor_left;
        logic motor_right;
        logic fwd_light;
        logic left_light;
        logic right_light;
        logic stop_light;
    } out_s;

    // Output pattern of a state; a turn drives exactly one rotation motor.
    function automatic out_s decode_outputs(state_e st, logic dir_right, logic done);
        out_s o;
        o      = '0;
        o.done = done;
        case (st)
            ST_IDLE: begin
                o.cmd_ready  = 1'b1;
                o.stop_light = 1'b1;
            end
            ST_FWD: begin
                o.cmd_ready = 1'b1;
                o.motor_fwd = 1'b1;
                o.fwd_light = 1'b1;
            end
            ST_TURN: begin
                o.busy = 1'b1;
                if (dir_right) begin
                    o.motor_right = 1'b1;
                    o.right_light = 1'b1;
                end else begin
                    o.motor_left = 1'b1;
                    o.left_light = 1'b1;
                end
            end
            ST_COOL: begin
                o.busy      = 1'b1;
                o.motor_fwd = 1'b1;
                o.fwd_light = 1'b1;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/semiauto_motion_exec_if.sv
// Command/status bundle between the decision FSM (master) and the motion executor (slave).
interface semiauto_motion_exec_if;
    logic       power;
    logic       cmd_valid;
    logic [3:0] cmd;
    logic       uturn;
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic       motor_fwd;
    logic       motor_left;
    logic       motor_right;
    logic       fwd_light;
    logic       left_light;
    logic       right_light;
    logic       stop_light;

    modport master (
        output power, cmd_valid, cmd, uturn,
        input  cmd_ready, busy, done, motor_fwd, motor_left, motor_right,
               fwd_light, left_light, right_light, stop_light
    );

    modport slave (
        input  power, cmd_valid, cmd, uturn,
        output cmd_ready, busy, done, motor_fwd, motor_left, motor_right,
               fwd_light, left_light, right_light, stop_light
    );
endinterface

// File: rtl/semiauto_tick_timer.sv
// Millisecond prescaler plus tick counter; o_expire fires on the tick that
// completes i_limit ticks since the last clear.
module semiauto_tick_timer #(
    parameter int TICK_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick   = (r_pre == CNT_W'(TICK_DIV - 1));
    assign o_expire = w_tick && (r_cnt == (i_limit - CNT_W'(1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_pre <= r_pre + CNT_W'(1);
        end
    end

endmodule

// File: rtl/semiauto_motion_exec.sv
// Motion executor: runs STOP/FORWARD/turn commands, times turns and the forced-forward
// cooldown that follows, and drives registered motor/lamp outputs.
module semiauto_motion_exec
    import semiauto_motion_exec_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int TURN_MS  = 800,
    parameter int COOL_MS  = 500,
    parameter int CNT_W    = 17
) (
    input  logic                  i_sys_clk,
    input  logic                  i_rst_n,
    semiauto_motion_exec_if.slave io_bus
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_dir_right;
    logic             r_uturn;
    logic             w_dir_right_nxt;
    logic             w_uturn_nxt;
    logic             w_done_nxt;
    logic             w_accept;
    logic             w_clear;
    logic             w_expire;
    logic [CNT_W-1:0] w_limit;
    out_s             r_out;

    assign w_accept = io_bus.cmd_valid && ((r_state == ST_IDLE) || (r_state == ST_FWD));

    always_comb begin
        if (r_state == ST_TURN)
            w_limit = r_uturn ? CNT_W'(2 * TURN_MS) : CNT_W'(TURN_MS);
        else
            w_limit = CNT_W'(COOL_MS);
    end

    // Timer restarts on every state change and is held clear outside TURN/COOL,
    // so each timed phase has an exact length regardless of history.
    assign w_clear = (w_state_nxt != r_state) ||
                     !((w_state_nxt == ST_TURN) || (w_state_nxt == ST_COOL));

    semiauto_tick_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_timer (
        .i_clk    (i_sys_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_clear),
        .i_limit  (w_limit),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_dir_right_nxt = r_dir_right;
        w_uturn_nxt     = r_uturn;
        w_done_nxt      = 1'b0;
        case (r_state)
            ST_IDLE, ST_FWD: begin
                if (w_accept) begin
                    case (io_bus.cmd)
                        CMD_FWD:   w_state_nxt = ST_FWD;
                        CMD_LEFT: begin
                            w_state_nxt     = ST_TURN;
                            w_dir_right_nxt = 1'b0;
                            w_uturn_nxt     = 1'b0;
                        end
                        CMD_RIGHT: begin
                            w_state_nxt     = ST_TURN;
                            w_dir_right_nxt = 1'b1;
                            w_uturn_nxt     = io_bus.uturn;
                        end
                        default:   w_state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_TURN: begin
                if (w_expire)
                    w_state_nxt = ST_COOL;
            end
            ST_COOL: begin
                if (w_expire) begin
                    w_state_nxt = ST_FWD;
                    w_done_nxt  = 1'b1;
                end
            end
        endcase
        // Power loss overrides everything, including a turn that is just finishing.
        if (!io_bus.power) begin
            w_state_nxt     = ST_IDLE;
            w_dir_right_nxt = 1'b0;
            w_uturn_nxt     = 1'b0;
            w_done_nxt      = 1'b0;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_dir_right <= 1'b0;
            r_uturn     <= 1'b0;
            r_out       <= decode_outputs(ST_IDLE, 1'b0, 1'b0);
        end else begin
            r_state     <= w_state_nxt;
            r_dir_right <= w_dir_right_nxt;
            r_uturn     <= w_uturn_nxt;
            r_out       <= decode_outputs(w_state_nxt, w_dir_right_nxt, w_done_nxt);
        end
    end

    assign io_bus.cmd_ready   = r_out.cmd_ready;
    assign io_bus.busy        = r_out.busy;
    assign io_bus.done        = r_out.done;
    assign io_bus.motor_fwd   = r_out.motor_fwd;
    assign io_bus.motor_left  = r_out.motor_left;
    assign io_bus.motor_right = r_out.motor_right;
    assign io_bus.fwd_light   = r_out.fwd_light;
    assign io_bus.left_light  = r_out.left_light;
    assign io_bus.right_light = r_out.right_light;
    assign io_bus.stop_light  = r_out.stop_light;

endmodule

// File: tb/tb_semiauto_motion_exec.sv
// Directed bench for semiauto_motion_exec with a small timing setup (4 clk/tick, 3-tick
// turns, 2-tick cooldown); output vector order: ready,busy,done,mf,ml,mr,fl,ll,rl,sl.
module tb_semiauto_motion_exec;
    import semiauto_motion_exec_pkg::*;

    localparam logic [9:0] V_IDLE     = 10'h201;
    localparam logic [9:0] V_FWD      = 10'h248;
    localparam logic [9:0] V_FWD_DONE = 10'h2C8;
    localparam logic [9:0] V_TURN_L   = 10'h124;
    localparam logic [9:0] V_TURN_R   = 10'h112;
    localparam logic [9:0] V_COOL     = 10'h148;

    logic       clk = 1'b0;
    logic       rstN;
    logic [9:0] outs;
    int         testCount = 0;
    int         failCount = 0;
    int         runLen;

    always #5 clk = ~clk;

    semiauto_motion_exec_if bus ();

    semiauto_motion_exec #(
        .TICK_DIV (4),
        .TURN_MS  (3),
        .COOL_MS  (2),
        .CNT_W    (17)
    ) dut (
        .i_sys_clk (clk),
        .i_rst_n   (rstN),
        .io_bus    (bus.slave)
    );

    assign outs = {bus.cmd_ready, bus.busy, bus.done, bus.motor_fwd, bus.motor_left,
                   bus.motor_right, bus.fwd_light, bus.left_light, bus.right_light,
                   bus.stop_light};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] c, input logic u);
        bus.cmd       = c;
        bus.uturn     = u;
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        bus.uturn     = 1'b0;
        bus.cmd       = CMD_STOP;
    endtask

    // Counts consecutive cycles with outputs equal to v; noise pulses a STOP command
    // every other cycle, which must be ignored while the executor is busy.
    task automatic runLength(input logic [9:0] v, input bit noise, output int n);
        n = 0;
        while (outs == v && n < 200) begin
            bus.cmd       = CMD_STOP;
            bus.cmd_valid = noise & n[0];
            step();
            n++;
        end
        bus.cmd_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rstN === 1'b1)
            checkOutput("motor_onehot",
                        {31'b0, (int'(bus.motor_fwd) + int'(bus.motor_left) + int'(bus.motor_right)) > 1},
                        32'd0);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN          = 1'b0;
        bus.power     = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd       = CMD_STOP;
        bus.uturn     = 1'b0;
        step();
        step();
        checkOutput("reset_idle", outs, V_IDLE);
        rstN = 1'b1;
        step();
        checkOutput("idle_hold", outs, V_IDLE);
        applyStimulus(4'b0110, 1'b0);
        checkOutput("idle_illegal", outs, V_IDLE);

        // Forward, and a repeated FORWARD keeps driving forward
        applyStimulus(CMD_FWD, 1'b0);
        checkOutput("t1_fwd", outs, V_FWD);
        applyStimulus(CMD_FWD, 1'b0);
        checkOutput("fwd_again", outs, V_FWD);

        // 90-degree left: 12 turn cycles, 8 cooldown cycles, single done pulse
        applyStimulus(CMD_LEFT, 1'b0);
        runLength(V_TURN_L, 1'b0, runLen);
        checkOutput("t2_left_len", runLen, 12);
        runLength(V_COOL, 1'b0, runLen);
        checkOutput("t2_cool_len", runLen, 8);
        checkOutput("t2_done", outs, V_FWD_DONE);
        step();
        checkOutput("t2_done_once", outs, V_FWD);

        // U-turn right with ignored command pulses during turn and cooldown
        applyStimulus(CMD_RIGHT, 1'b1);
        runLength(V_TURN_R, 1'b1, runLen);
        checkOutput("t3_uturn_len", runLen, 24);
        runLength(V_COOL, 1'b1, runLen);
        checkOutput("t3_cool_len", runLen, 8);
        checkOutput("t3_done", outs, V_FWD_DONE);
        step();
        checkOutput("t3_after", outs, V_FWD);

        // uturn qualifier on LEFT has no effect
        applyStimulus(CMD_LEFT, 1'b1);
        runLength(V_TURN_L, 1'b0, runLen);
        checkOutput("left_uturn_len", runLen, 12);
        runLength(V_COOL, 1'b0, runLen);
        checkOutput("left_uturn_cool", runLen, 8);
        checkOutput("left_uturn_done", outs, V_FWD_DONE);
        step();

        // Power drop at cycle 5 of a turn
        applyStimulus(CMD_LEFT, 1'b0);
        checkOutput("t4_turn", outs, V_TURN_L);
        repeat (4) step();
        bus.power = 1'b0;
        step();
        checkOutput("t4_off", outs, V_IDLE);
        applyStimulus(CMD_FWD, 1'b0);
        checkOutput("t4_off_cmd", outs, V_IDLE);
        repeat (20) step();
        checkOutput("t4_no_done", outs, V_IDLE);
        bus.power = 1'b1;
        step();
        checkOutput("t4_repower", outs, V_IDLE);
        applyStimulus(CMD_FWD, 1'b0);
        checkOutput("t4_fwd", outs, V_FWD);
        applyStimulus(CMD_RIGHT, 1'b0);
        runLength(V_TURN_R, 1'b0, runLen);
        checkOutput("t4_right_len", runLen, 12);
        runLength(V_COOL, 1'b0, runLen);
        checkOutput("t4_cool_len", runLen, 8);
        checkOutput("t4_done", outs, V_FWD_DONE);
        step();

        // Asynchronous reset in the middle of cooldown
        applyStimulus(CMD_LEFT, 1'b0);
        runLength(V_TURN_L, 1'b0, runLen);
        repeat (3) step();
        checkOutput("t5_cool", outs, V_COOL);
        #2 rstN = 1'b0;
        #1 checkOutput("t5_async", outs, V_IDLE);
        step();
        rstN = 1'b1;
        repeat (12) step();
        checkOutput("t5_no_done", outs, V_IDLE);
        applyStimulus(CMD_STOP, 1'b0);
        checkOutput("t5_stop", outs, V_IDLE);

        // Illegal code while moving forward stops the car
        applyStimulus(CMD_FWD, 1'b0);
        checkOutput("t6_fwd", outs, V_FWD);
        applyStimulus(4'b0110, 1'b0);
        checkOutput("t6_illegal", outs, V_IDLE);
        applyStimulus(CMD_FWD, 1'b0);
        applyStimulus(CMD_STOP, 1'b0);
        checkOutput("t6_stop", outs, V_IDLE);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
